// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_stage_pkg : shared encodings for the MEM stage | rev 1.0
// ----------------------------------------------------------------------------
package mem_access_stage_pkg;

  typedef enum logic [0:0] {
    ISSUE = 1'b0,
    RESP  = 1'b1
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (is_load) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_load_align : lane select and sign/zero extension of a load word | rev 1.0
// ----------------------------------------------------------------------------
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'b00:   lane_b = rdata[7:0];
      2'b01:   lane_b = rdata[15:8];
      2'b10:   lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_BU:   result = {24'h000000, lane_b};
      F3_HU:   result = {16'h0000, lane_h};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_stage : MEM pipeline stage with dmem req/gnt/rvalid handshake | rev 1.0
// ----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_reg_write,
  output logic            mem_fault
);

  localparam int            CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  state_e          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            memop, is_load, legal, misaligned, bad, rd_nz;
  logic [1:0]      addr_lo;
  logic [XLEN-1:0] load_data;
  logic            req_c, stall_c, fault_c;
  logic            nxt_valid, nxt_we;
  logic [4:0]      nxt_rd;
  logic [XLEN-1:0] nxt_data;

  assign addr_lo    = ex_alu_result[1:0];
  assign memop      = ex_valid & (ex_mem_read | ex_mem_write);
  assign is_load    = ex_mem_read;
  assign legal      = f3_legal(is_load, ex_funct3);
  assign misaligned = (ex_funct3[1:0] == 2'b01 && addr_lo[0]) ||
                      (ex_funct3[1:0] == 2'b10 && addr_lo != 2'b00);
  assign bad        = ~legal | misaligned;
  assign rd_nz      = |ex_rd;

  assign dmem_we   = ex_mem_write & ~ex_mem_read;
  assign dmem_addr = {ex_alu_result[XLEN-1:2], 2'b00};

  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        dmem_be    = BE_BYTE << addr_lo;
        dmem_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        dmem_be    = BE_HALF << {addr_lo[1], 1'b0};
        dmem_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        dmem_be    = BE_WORD;
        dmem_wdata = ex_store_data;
      end
    endcase
  end

  mem_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo),
    .funct3  (ex_funct3),
    .result  (load_data)
  );

  // EX/MEM is frozen while stalled, so the ex_* inputs still describe the load in RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    fault_c   = 1'b0;
    nxt_valid = 1'b0;
    nxt_we    = 1'b0;
    nxt_rd    = 5'd0;
    nxt_data  = '0;
    case (state)
      ISSUE: begin
        if (!memop) begin
          nxt_valid = ex_valid;
          nxt_rd    = ex_rd;
          nxt_data  = ex_alu_result;
          nxt_we    = ex_valid & ex_reg_write & rd_nz;
        end else if (bad) begin
          fault_c = 1'b1;
        end else begin
          req_c = 1'b1;
          if (!dmem_gnt) begin
            stall_c = 1'b1;
          end else if (is_load) begin
            stall_c   = 1'b1;
            state_nxt = RESP;
            cnt_nxt   = '0;
          end else begin
            nxt_valid = 1'b1;
            nxt_rd    = ex_rd;
            nxt_data  = ex_alu_result;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          nxt_valid = 1'b1;
          nxt_rd    = ex_rd;
          nxt_data  = load_data;
          nxt_we    = ex_reg_write & rd_nz;
          state_nxt = ISSUE;
        end else if (TIMEOUT_CYCLES != 0 && cnt == TMO) begin
          fault_c   = 1'b1;
          state_nxt = ISSUE;
        end else begin
          stall_c = 1'b1;
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ISSUE;
    endcase
  end

  assign dmem_req  = req_c & reset;
  assign stall     = stall_c & reset;
  assign mem_fault = fault_c & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ISSUE;
      cnt          <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      wb_valid     <= nxt_valid;
      wb_rd        <= nxt_rd;
      wb_data      <= nxt_data;
      wb_reg_write <= nxt_we;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM pipeline register and feeding the WB stage.
- Consumes the registered ALU result (address or pass-through value), store data, Rd and control bits.
- Runs a request/grant/response handshake with data memory, formats loads and stores (byte/half/word, sign/zero extend), and stalls upstream while an access is outstanding.
- Registers the result into the MEM/WB boundary.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting in RESP for dmem_rvalid; 0 disables the timeout.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- ex_valid  input  1  EX/MEM slot holds a real instruction.
- ex_alu_result  input  32  effective address, or result for non-memory ops.
- ex_store_data  input  32  rs2 value for stores.
- ex_rd  input  5  destination register.
- ex_funct3  input  3  access size/sign.
- ex_mem_read  input  1  load.
- ex_mem_write  input  1  store.
- ex_reg_write  input  1  instruction writes Rd.
- dmem_req  output  1  access request.
- dmem_we  output  1  1=store.
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  output  4  byte enables.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_gnt  input  1  request accepted this cycle.
- dmem_rvalid  input  1  load data valid.
- dmem_rdata  input  32  load word.
- stall  output  1  freeze EX/MEM and earlier stages.
- wb_valid  output  1  MEM/WB slot valid.
- wb_rd  output  5  MEM/WB Rd.
- wb_data  output  32  MEM/WB result.
- wb_reg_write  output  1  MEM/WB write enable.
- mem_fault  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout.

Behaviour:
- Reset: state=ISSUE, timeout counter=0. wb_valid, wb_rd, wb_data, wb_reg_write and mem_fault are all 0. dmem_req is 0 while reset is asserted.
- memop = ex_valid & (ex_mem_read | ex_mem_write). If both read and write are set, the access is treated as a load.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
- ISSUE state:
  - Non-memop: stall=0, dmem_req=0. At the clock edge the WB register takes wb_data=ex_alu_result and wb_valid=ex_valid.
  - memop that is illegal or misaligned: dmem_req=0, stall=0, mem_fault=1 for this cycle. WB register loads a bubble.
  - Legal memop: dmem_req=1 combinationally, with addr/be/wdata/we derived from the current inputs.
    - Store with dmem_gnt=1: completes this cycle, stall=0. WB register loads wb_valid=1, wb_reg_write=0.
    - Load with dmem_gnt=1: stall=1, next state=RESP, counter cleared.
    - No grant: stall=1, stay in ISSUE and re-request. Inputs are held because stall=1.
- RESP state:
  - dmem_req=0.
  - dmem_rvalid=1: stall=0, WB register takes the formatted load data, next state=ISSUE. Load-to-WB latency is the grant-to-rvalid gap plus 1 edge.
  - Otherwise: stall=1 and the counter increments.
  - Counter reaching TIMEOUT_CYCLES (when nonzero): mem_fault pulse, stall=0, WB bubble, next state=ISSUE.
- Whenever stall=1, the WB register loads a bubble (wb_valid=0, wb_reg_write=0). wb_rd and wb_data are don't-care but are driven to 0.
- wb_reg_write = ex_reg_write & valid completion & (ex_rd != 0).
- Store formatting:
  - SB: be=0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{half}}.
  - SW: be=1111.
- Load formatting: select the byte or half lane using addr[1:0], then sign- or zero-extend to 32 bits.
- dmem_rvalid while in ISSUE and dmem_gnt while dmem_req=0 are both ignored.
- Reset asserted mid-access drops the outstanding access. Any late rvalid after reset is ignored.

Decomposition:
- Shared package holds the funct3 load/store encodings, the state enum {ISSUE, RESP} and the be lane constants.
- One combinational sub-module, mem_load_align, takes rdata, addr[1:0] and funct3 and produces the extended result. Store lane formatting stays inline.

Test Plan:
- Non-memop: ex_alu_result=0x0000_1234, rd=5, reg_write=1 -> next edge wb_data=0x1234, wb_rd=5, wb_reg_write=1, stall never asserted.
- SB, addr=0x103, data=0xAB, gnt same cycle -> dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, stall=0, wb_reg_write=0.
- LB, addr=0x2, gnt after 2 cycles, rvalid 3 cycles later, rdata=0x0080_0000 -> stall high 5 cycles, wb_data=0xFFFF_FF80. Same sequence with LBU -> wb_data=0x0000_0080.
- LW, addr=0x6 -> mem_fault pulses 1 cycle, dmem_req=0, stall=0, WB bubble. Same check for funct3=011.
- LW granted, no rvalid, TIMEOUT_CYCLES=4 -> stall for 4 RESP cycles, mem_fault pulse, return to ISSUE. A later stray rvalid produces no writeback.
- Reset low during RESP -> all outputs 0, state ISSUE. LW with rd=0 -> wb_valid=1, wb_reg_write=0.
